// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions for the encoder and reader sides.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
// Also holds the reader state enum and mod-10 step helpers.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOCKED = 1'b1
    } rd_state_t;

    // (d+1) mod 10 for d in 0..9
    function automatic logic [3:0] inc_mod10(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // (d-1) mod 10 for d in 0..9
    function automatic logic [3:0] dec_mod10(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment to BCD decoder.
// Ports:
//   seg_i    [6:0]  segment pattern {g,f,e,d,c,b,a}
//   legal_o         pattern is one of the ten digit glyphs
//   blank_o         pattern is all segments off
//   digit_o  [3:0]  decoded digit, 0 when not legal
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] digit_o
);

    always_comb begin
        legal_o = 1'b1;
        blank_o = 1'b0;
        digit_o = 4'd0;
        case (seg_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Seven-segment reader: samples a segment pattern every tick, accepts it
// once it has been stable for STABLE_TICKS ticks, decodes it to a digit and
// classifies each digit change as step up, step down (mod 10) or jump.
// Illegal stable patterns pulse pattern_err and bump a saturating counter.
// Ports:
//   tick_clk                 clock, rising edge
//   reset                    asynchronous, active-high
//   seg_in      [6:0]        segment pattern {g,f,e,d,c,b,a}
//   digit       [3:0]        last accepted digit
//   digit_valid              1 while locked onto a legal digit
//   step_up/step_dn/jump     1-tick change classification pulses
//   pattern_err              1-tick pulse on an accepted illegal pattern
//   err_count   [ERR_W-1:0]  saturating count of pattern_err pulses
module seven_segment_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_TICKS = 2,
    parameter int ERR_W        = 8
) (
    input  logic             tick_clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             jump,
    output logic             pattern_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] ST = 4'(STABLE_TICKS);

    logic [6:0]       seg_q, cand_q, cand_d;
    logic [3:0]       stab_q, stab_d;
    rd_state_t        state_q;
    logic [3:0]       digit_q;
    logic             up_q, dn_q, jump_q, perr_q;
    logic [ERR_W-1:0] err_q;

    logic             dec_legal, dec_blank;
    logic [3:0]       dec_digit;
    logic             accept;

    // Decode the candidate; on an accept edge it equals seg_q.
    seven_seg_decode u_dec (
        .seg_i   (cand_q),
        .legal_o (dec_legal),
        .blank_o (dec_blank),
        .digit_o (dec_digit)
    );

    // Stability tracking: any change restarts the count at 1; the count
    // saturates at ST so a held pattern is accepted only once.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (seg_q != cand_q) begin
            cand_d = seg_q;
            stab_d = 4'd1;
        end else if (stab_q < ST) begin
            stab_d = stab_q + 4'd1;
        end
    end

    assign accept = (seg_q == cand_q) && (stab_q == ST - 4'd1);

    always_ff @(posedge tick_clk or posedge reset) begin
        if (reset) begin
            seg_q  <= SEG_BLANK;
            cand_q <= SEG_BLANK;
            stab_q <= 4'd0;
        end else begin
            seg_q  <= seg_in;
            cand_q <= cand_d;
            stab_q <= stab_d;
        end
    end

    // Reader FSM with registered pulses; pulses default low every edge.
    always_ff @(posedge tick_clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            digit_q <= 4'd0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            jump_q  <= 1'b0;
            perr_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
            jump_q <= 1'b0;
            perr_q <= 1'b0;
            if (accept) begin
                if (dec_legal) begin
                    case (state_q)
                        EMPTY: begin
                            digit_q <= dec_digit;
                            state_q <= LOCKED;
                        end
                        LOCKED: begin
                            if (dec_digit != digit_q) begin
                                digit_q <= dec_digit;
                                if (dec_digit == inc_mod10(digit_q))
                                    up_q <= 1'b1;
                                else if (dec_digit == dec_mod10(digit_q))
                                    dn_q <= 1'b1;
                                else
                                    jump_q <= 1'b1;
                            end
                        end
                        default: state_q <= EMPTY;
                    endcase
                end else if (dec_blank) begin
                    state_q <= EMPTY;
                end else begin
                    state_q <= EMPTY;
                    perr_q  <= 1'b1;
                    if (err_q != '1)
                        err_q <= err_q + ERR_W'(1);
                end
            end
        end
    end

    assign digit       = digit_q;
    assign digit_valid = (state_q == LOCKED);
    assign step_up     = up_q;
    assign step_dn     = dn_q;
    assign jump        = jump_q;
    assign pattern_err = perr_q;
    assign err_count   = err_q;

endmodule
